apb_rr_master_arbiter: RTL and testbench
========================================

# apb_rr_master_arbiter

Round-robin arbiter and APB3 master sequencer that shares one APB master port between NUM_REQ requesters. It accepts simple valid/hold requests, grants one at a time, and drives the SETUP/ACCESS phases on the `apb_if_rev_b` master side. A watchdog terminates stalled transfers with an error response. It sits between local bus clients (DMA, CPU bridge, debug) and the peripheral APB fabric.

## Interface
- NUM_REQ, 4, number of requesters (2..16)
- ADDR_WIDTH, 32, APB address width
- DATA_WIDTH, 32, APB data width
- TIMEOUT_CYCLES, 16, max ACCESS cycles without pready before forced error; 0 disables

Ports:
- pclk  in  1  clock
- preset  in  1  asynchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester request; held with its payload stable until that requester's rsp_valid
- req_write  in  NUM_REQ  1 = write
- req_addr  in  NUM_REQ*ADDR_WIDTH  flattened; requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_wdata  in  NUM_REQ*DATA_WIDTH  flattened, same packing
- rsp_valid  out  NUM_REQ  one-hot completion pulse, one cycle
- rsp_rdata  out  DATA_WIDTH  read data, valid with rsp_valid
- rsp_err  out  1  pslverr or timeout, valid with rsp_valid
- gnt_id  out  $clog2(NUM_REQ)  index of the requester currently owning the bus
- busy  out  1  high in SETUP/ACCESS
- apb  master modport of apb_if_rev_b: paddr, pselx, penable, pwrite, pwdata out; pready, prdata, pslverr in

## Operation
- FSM states: IDLE, SETUP, ACCESS.
- IDLE: if any req_valid, arbiter picks the winner; register gnt_id, paddr, pwrite, pwdata from the winner; next state SETUP. Otherwise stay.
- Round-robin: search starts at last_grant+1 mod NUM_REQ and wraps. last_grant updates on grant. Reset value NUM_REQ-1, so requester 0 wins first.
- SETUP: pselx=1, penable=0; next ACCESS unconditionally.
- ACCESS: pselx=1, penable=1, counter increments each cycle. If pready=1: rsp_valid[gnt_id]=1 combinationally that cycle, rsp_rdata=prdata for reads, else 0; rsp_err=pslverr; next IDLE. If pready=0 and counter reaches TIMEOUT_CYCLES-1: rsp_valid[gnt_id]=1, rsp_rdata=0, rsp_err=1; next IDLE.
- Requester contract: on the cycle after rsp_valid, drop req_valid or present a new request. A new request from the same requester is arbitrated normally, with no priority retention.
- paddr/pwrite/pwdata hold stable from SETUP through the final ACCESS cycle and are unchanged in IDLE.
- req_valid deasserted by an ungranted requester: ignored. Deassertion by the granted requester mid-transfer: illegal; the transfer completes regardless.

## Timing
- Reset (async assert, sync deassert expected upstream): pselx=0, penable=0, paddr=0, pwrite=0, pwdata=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, gnt_id=0, busy=0, counter=0, state IDLE.
- Reset mid-transfer: pselx/penable drop immediately. No rsp_valid is issued; the requester must reissue.
- Latency with zero-wait slave: req_valid seen in IDLE at cycle 0, SETUP at 1, ACCESS with rsp_valid at 2. Minimum 3 cycles per transfer, including one IDLE cycle between transfers.
- Timeout: rsp_err asserted in ACCESS cycle TIMEOUT_CYCLES, counting from 1.
- Counter width is $clog2(TIMEOUT_CYCLES+1). It clears on entry to SETUP.
- rsp_rdata, rsp_err and rsp_valid are combinational from pready/prdata/pslverr in ACCESS. All other outputs are registered.

## Structure
- apb_pkg: apb_state_e {IDLE, SETUP, ACCESS}.
- Sub-module apb_rr_arbiter: combinational round-robin pick from (req vector, last_grant) to (any, idx). It is reusable elsewhere.
- Top holds the FSM, payload registers, last_grant and timeout counter.

## Test plan
- Single read, req 2, addr 0x40, slave pready immediate, prdata 0xDEADBEEF -> SETUP at cycle 1, ACCESS at cycle 2, rsp_valid=4'b0100, rsp_rdata 0xDEADBEEF, rsp_err 0.
- All 4 requesting continuously from reset -> grant order 0,1,2,3,0; each transfer is 3 cycles.
- Write from req 1 with slave inserting 3 wait states -> pselx/penable/paddr/pwdata stable for 4 ACCESS cycles; rsp_valid on the 4th.
- Slave never asserts pready, TIMEOUT_CYCLES=16 -> rsp_err=1, rsp_rdata=0 in ACCESS cycle 16; next cycle pselx=0.
- pslverr=1 with pready on a read -> rsp_err=1 and rsp_valid pulse; next grant proceeds normally.
- Assert preset during ACCESS -> pselx/penable 0 immediately, no rsp_valid; after release, requester 0 wins first.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared types for the APB round-robin master arbiter.
// Holds the sequencer FSM state encoding.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } apb_state_e;

endpackage

// File: rtl/apb_if_rev_b.sv
// APB3 bus bundle: master drives paddr/pselx/penable/pwrite/pwdata,
// slave returns pready/prdata/pslverr.
interface apb_if_rev_b #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] paddr;
  logic                  pselx;
  logic                  penable;
  logic                  pwrite;
  logic [DATA_WIDTH-1:0] pwdata;
  logic                  pready;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pslverr;

  modport master (
    output paddr, pselx, penable, pwrite, pwdata,
    input  pready, prdata, pslverr
  );

  modport slave (
    input  paddr, pselx, penable, pwrite, pwdata,
    output pready, prdata, pslverr
  );
endinterface

// File: rtl/apb_rr_master_arbiter_arb.sv
// Combinational round-robin pick: search starts at last+1 and wraps.
// Ports: req vector, last grant index in; any/idx of winner out.
module apb_rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic          any,
  output logic [IW-1:0] idx
);

  always_comb begin
    any = 1'b0;
    idx = '0;
    for (int i = 1; i <= N; i++) begin
      if (!any && req[(int'(last) + i) % N]) begin
        any = 1'b1;
        idx = IW'((int'(last) + i) % N);
      end
    end
  end

endmodule

// File: rtl/apb_rr_master_arbiter.sv
// Round-robin arbiter + APB3 master sequencer with access watchdog.
// Ports: per-requester valid/write/addr/wdata in; rsp_* out; apb master.
module apb_rr_master_arbiter
  import apb_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                          pclk,
  input  logic                          preset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic                          rsp_err,
  output logic [$clog2(NUM_REQ)-1:0]    gnt_id,
  output logic                          busy,
  apb_if_rev_b.master                   apb
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW =
    (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CW-1:0] TO_LAST =
    CW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  apb_state_e            state_q, state_d;
  logic [IW-1:0]         gnt_q, gnt_d;
  logic [IW-1:0]         last_q, last_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic                  pwrite_q, pwrite_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic [CW-1:0]         cnt_q, cnt_d;

  logic          arb_any;
  logic [IW-1:0] arb_idx;

  apb_rr_arbiter #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_arb (
    .req  (req_valid),
    .last (last_q),
    .any  (arb_any),
    .idx  (arb_idx)
  );

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    last_d    = last_q;
    paddr_d   = paddr_q;
    pwrite_d  = pwrite_q;
    pwdata_d  = pwdata_q;
    cnt_d     = cnt_q;
    rsp_valid = '0;
    rsp_rdata = '0;
    rsp_err   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (arb_any) begin
          state_d  = SETUP;
          gnt_d    = arb_idx;
          last_d   = arb_idx;
          paddr_d  = req_addr[arb_idx*ADDR_WIDTH +: ADDR_WIDTH];
          pwrite_d = req_write[arb_idx];
          pwdata_d = req_wdata[arb_idx*DATA_WIDTH +: DATA_WIDTH];
          cnt_d    = '0;
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        cnt_d = cnt_q + CW'(1);
        if (apb.pready) begin
          rsp_valid[gnt_q] = 1'b1;
          rsp_rdata = pwrite_q ? '0 : apb.prdata;
          rsp_err   = apb.pslverr;
          state_d   = IDLE;
        end else if (TO_EN && cnt_q == TO_LAST) begin
          // watchdog: stalled slave gets an error response
          rsp_valid[gnt_q] = 1'b1;
          rsp_err = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      last_q   <= IW'(NUM_REQ - 1);
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      last_q   <= last_d;
      paddr_q  <= paddr_d;
      pwrite_q <= pwrite_d;
      pwdata_q <= pwdata_d;
      cnt_q    <= cnt_d;
    end
  end

  assign apb.pselx   = (state_q != IDLE);
  assign apb.penable = (state_q == ACCESS);
  assign apb.paddr   = paddr_q;
  assign apb.pwrite  = pwrite_q;
  assign apb.pwdata  = pwdata_q;
  assign gnt_id      = gnt_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_apb_rr_master_arbiter.sv
// Directed bench for apb_rr_master_arbiter: vector table plus
// round-robin, timeout and mid-transfer reset sequences.
module tb_apb_rr_master_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req_valid;
  logic [3:0]   req_write;
  logic [127:0] req_addr;
  logic [127:0] req_wdata;
  logic [3:0]   rsp_valid;
  logic [31:0]  rsp_rdata;
  logic         rsp_err;
  logic [1:0]   gnt_id;
  logic         busy;

  int n_run  = 0;
  int n_fail = 0;

  apb_if_rev_b #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  apb_rr_master_arbiter #(
    .NUM_REQ        (4),
    .ADDR_WIDTH     (32),
    .DATA_WIDTH     (32),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .pclk      (clk),
    .preset    (rst),
    .req_valid (req_valid),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .gnt_id    (gnt_id),
    .busy      (busy),
    .apb       (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          waits;
    logic [31:0] prdata;
    logic        slverr;
    logic [3:0]  exp_vld;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vt[5];

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic load_req(input int id, input logic wr,
                          input logic [31:0] a, input logic [31:0] d);
    req_write[id] = wr;
    req_addr[id*32 +: 32]  = a;
    req_wdata[id*32 +: 32] = d;
  endtask

  task automatic run_vec(input vec_t v);
    @(negedge clk);
    load_req(v.id, v.wr, v.addr, v.wdata);
    req_valid = 4'(1 << v.id);
    bus.pready = 1'b0;
    @(negedge clk);
    chk("setup", 128'({busy, bus.pselx, bus.penable, bus.pwrite,
                       gnt_id, bus.paddr, bus.pwdata}),
        128'({1'b1, 1'b1, 1'b0, v.wr, 2'(v.id), v.addr, v.wdata}));
    for (int k = 1; k <= v.waits + 1; k++) begin
      @(negedge clk);
      bus.pready  = (k == v.waits + 1);
      bus.prdata  = v.prdata;
      bus.pslverr = v.slverr;
      #1;
      if (k <= v.waits)
        chk("wait", 128'({rsp_valid, bus.pselx, bus.penable,
                          bus.paddr, bus.pwdata}),
            128'({4'b0, 1'b1, 1'b1, v.addr, v.wdata}));
      else
        chk("rsp", 128'({rsp_valid, rsp_rdata, rsp_err, bus.penable}),
            128'({v.exp_vld, v.exp_rdata, v.exp_err, 1'b1}));
    end
    @(negedge clk);
    req_valid  = '0;
    bus.pready = 1'b0;
    chk("idle", 128'({busy, bus.pselx, bus.penable, bus.paddr}),
        128'({1'b0, 1'b0, 1'b0, v.addr}));
  endtask

  initial begin
    int ord[5];
    logic early;
    ord = '{0, 1, 2, 3, 0};

    vt[0] = '{2, 1'b0, 32'h40, 32'h0, 0, 32'hDEADBEEF, 1'b0,
              4'b0100, 32'hDEADBEEF, 1'b0};
    vt[1] = '{1, 1'b1, 32'h100, 32'hA5A55A5A, 3, 32'h1234, 1'b0,
              4'b0010, 32'h0, 1'b0};
    vt[2] = '{3, 1'b0, 32'h8, 32'h0, 0, 32'hCAFEF00D, 1'b1,
              4'b1000, 32'hCAFEF00D, 1'b1};
    vt[3] = '{0, 1'b1, 32'hFFFFFFFC, 32'h1, 1, 32'h5555, 1'b1,
              4'b0001, 32'h0, 1'b1};
    vt[4] = '{2, 1'b0, 32'h44, 32'h0, 2, 32'h0BADC0DE, 1'b0,
              4'b0100, 32'h0BADC0DE, 1'b0};

    rst         = 1'b1;
    req_valid   = '0;
    req_write   = '0;
    req_addr    = '0;
    req_wdata   = '0;
    bus.pready  = 1'b0;
    bus.prdata  = 32'h0;
    bus.pslverr = 1'b0;

    repeat (2) @(negedge clk);
    #1;
    chk("rst_apb", 128'({bus.pselx, bus.penable, bus.pwrite,
                         bus.paddr, bus.pwdata}), 128'(0));
    chk("rst_out", 128'({rsp_valid, rsp_rdata, rsp_err, gnt_id, busy}),
        128'(0));

    // all four requesting continuously from reset
    for (int i = 0; i < 4; i++)
      load_req(i, 1'b0, 32'h1000 + 32'(i * 16), 32'h0);
    bus.pready = 1'b1;
    bus.prdata = 32'h77;
    req_valid  = 4'hF;
    rst        = 1'b0;
    for (int t = 0; t < 5; t++) begin
      @(negedge clk);
      chk("rr_setup", 128'({gnt_id, bus.pselx, bus.penable, bus.paddr}),
          128'({2'(ord[t]), 1'b1, 1'b0, 32'h1000 + 32'(ord[t] * 16)}));
      @(negedge clk);
      #1;
      chk("rr_rsp", 128'({rsp_valid, rsp_rdata}),
          128'({4'(1 << ord[t]), 32'h77}));
      @(negedge clk);
      chk("rr_idle", 128'({busy, bus.pselx}), 128'(0));
      if (t == 4) req_valid = '0;
    end
    bus.pready = 1'b0;

    for (int i = 0; i < 5; i++) run_vec(vt[i]);

    // watchdog: slave never responds
    @(negedge clk);
    load_req(3, 1'b0, 32'h200, 32'h0);
    req_valid   = 4'b1000;
    bus.pready  = 1'b0;
    bus.pslverr = 1'b0;
    bus.prdata  = 32'hFFFFFFFF;
    early       = 1'b0;
    @(negedge clk);
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      #1;
      if (k < 16) early = early | (|rsp_valid) | rsp_err | ~bus.penable;
      else
        chk("to_rsp", 128'({rsp_valid, rsp_rdata, rsp_err}),
            128'({4'b1000, 32'h0, 1'b1}));
    end
    chk("to_early", 128'(early), 128'(0));
    @(negedge clk);
    req_valid = '0;
    chk("to_idle", 128'({bus.pselx, bus.penable}), 128'(0));

    // reset in the middle of an ACCESS phase
    @(negedge clk);
    load_req(1, 1'b0, 32'h300, 32'h0);
    req_valid = 4'b0010;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("pre_rst", 128'({bus.pselx, bus.penable, gnt_id}),
        128'({1'b1, 1'b1, 2'd1}));
    rst = 1'b1;
    #1;
    chk("rst_mid", 128'({bus.pselx, bus.penable, busy, rsp_valid, gnt_id}),
        128'(0));
    load_req(0, 1'b0, 32'h400, 32'h0);
    load_req(2, 1'b0, 32'h500, 32'h0);
    req_valid = 4'b0111;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_rr", 128'({gnt_id, bus.pselx, bus.penable, bus.paddr}),
        128'({2'd0, 1'b1, 1'b0, 32'h400}));
    bus.pready = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_rsp", 128'(rsp_valid), 128'(4'b0001));
    @(negedge clk);
    req_valid  = '0;
    bus.pready = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
